if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decoder.
- Owns the PC and issues instruction reads as a Wishbone classic master.
- Holds the IF/ID pipeline register and presents the instruction to ID already split into fields (opcode, immediates, register indices).
- Obeys stall and flush from the hazard unit and redirects from EX.

Parameters:
PC_ADDR, 32'h8000_0000, PC value loaded at reset
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; instruction width

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
stall_i  in  1  hazard unit: hold IF/ID contents
flush_i  in  1  hazard unit: kill IF/ID contents (insert bubble)
branch_taken_i  in  1  EX: redirect fetch
branch_target_i  in  ADDR_WIDTH  redirect address
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_ack_i  in  1  Wishbone acknowledge
wb_adr_o  out  ADDR_WIDTH  fetch address
wb_dat_i  in  DATA_WIDTH  read data
wb_dat_o  out  DATA_WIDTH  constant 0
wb_we_o  out  1  constant 0
wb_sel_o  out  DATA_WIDTH/8  constant all ones
if_id_valid_o  out  1  IF/ID holds a real instruction
if_id_pc_o  out  ADDR_WIDTH  PC of the IF/ID instruction
instruction  out  32  IF/ID instruction word
opcode, rd, rs1, rs2, funct3  out  7/5/5/5/3  fields split combinationally from instruction
I_imm, S_imm, SB_imm  out  12 each  I-type, S-type and branch immediates (SB_imm = {inst[31],inst[7],inst[30:25],inst[11:8]})
U_imm, UJ_imm  out  20 each  U-type and jump immediates (UJ_imm = {inst[31],inst[19:12],inst[20],inst[30:21]})

Behaviour:
- Reset (reset low, asynchronous):
  - pc = PC_ADDR; state IDLE; wb_cyc_o = wb_stb_o = 0.
  - instruction = 32'h0000_0013 (NOP); if_id_valid_o = 0; if_id_pc_o = 0.
  - Redirect-pending flag and hold buffer cleared.
- Reset asserted mid-transaction drops cyc/stb immediately; a late ack after release is ignored, since cyc is low.
- FSM states:
  - IDLE: cyc/stb low for exactly 1 cycle, then REQ.
  - REQ: cyc = stb = 1, wb_adr_o = pc; stays until wb_ack_i.
  - HOLD: fetched word parked in buffer while stall_i is high.
- On ack in REQ, no redirect pending:
  - if stall_i = 0: load IF/ID (instruction = wb_dat_i, pc, valid = 1); pc += 4; go to IDLE.
  - if stall_i = 1: buffer = wb_dat_i, buffer_pc = pc; pc += 4; go to HOLD.
- HOLD: when stall_i = 0, load IF/ID from the buffer and go to IDLE.
- Throughput: with zero-wait ack, one instruction per 2 cycles. First request is issued on the 2nd cycle after reset release. Ack-to-IF/ID latency is 1 edge.
- IF/ID register, evaluated every edge in this priority order:
  1. flush_i = 1 → valid = 0, instruction = NOP (overrides stall_i).
  2. else stall_i = 1 → hold all contents.
  3. else new word available → load it.
  4. else → valid = 0, instruction = NOP (bubble).
- Redirect (branch_taken_i = 1):
  - Target is used with bits [1:0] forced to 0.
  - In IDLE or HOLD: pc = target; buffer discarded; go to IDLE.
  - In REQ without ack: the bus cycle is not aborted. Latch the target and set pending; the later ack's data is discarded, pc = latched target, go to IDLE.
  - In REQ with ack in the same cycle: data discarded, pc = target.
  - A newer redirect while pending overwrites the latched target.
  - A redirect never loads IF/ID in its own cycle. EX asserts flush_i alongside; the stage does not flush itself.
- Bus signals: wb_adr_o is stable for the whole REQ cycle. wb_we_o, wb_dat_o and wb_sel_o are constant.
- Arithmetic: pc + 4 wraps modulo 2^ADDR_WIDTH with no trap; 32'hFFFF_FFFC → 0.

Test Plan:
1. Reset release, ack always 1-cycle, words 0x00500093, 0x00100113 → wb_adr_o 0x80000000 then 0x80000004. IF/ID valid with pc 0x80000000, then 0x80000004. opcode = 0x13, rd = 1, I_imm = 5 for the first word.
2. Ack delayed 3 cycles → cyc/stb held, adr stable at 0x80000000 for 4 cycles; IF/ID loads on the edge after ack.
3. stall_i high across the ack for 4 cycles → IF/ID unchanged, state HOLD. On stall release the buffered word and its pc appear and the next fetch is 0x80000008.
4. branch_taken_i with target 0x80000102 during an un-acked REQ → that ack's data is discarded; the next request address is 0x80000100; no valid IF/ID from the discarded word.
5. flush_i and stall_i high together → if_id_valid_o = 0, instruction = 0x00000013 on the next edge.
6. reset low while cyc = 1 → cyc/stb drop without a clock edge. After release, pc restarts at 0x80000000 and a stray ack is ignored.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch with Wishbone classic master and field-split IF/ID register.
module if_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    branch_taken_i,
  input  logic [ADDR_WIDTH-1:0]   branch_target_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    if_id_valid_o,
  output logic [ADDR_WIDTH-1:0]   if_id_pc_o,
  output logic [31:0]             instruction,
  output logic [6:0]              opcode,
  output logic [4:0]              rd,
  output logic [4:0]              rs1,
  output logic [4:0]              rs2,
  output logic [2:0]              funct3,
  output logic [11:0]             I_imm,
  output logic [11:0]             S_imm,
  output logic [11:0]             SB_imm,
  output logic [19:0]             U_imm,
  output logic [19:0]             UJ_imm
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n, pend_tgt, pend_tgt_n, buf_pc, buf_pc_n, tgt, ld_pc;
  logic [DATA_WIDTH-1:0] buf_w, buf_w_n;
  logic                  pend, pend_n, ld;
  logic [31:0]           ld_w;
  assign tgt = branch_target_i & ~ADDR_WIDTH'(3);
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend;
    pend_tgt_n = pend_tgt;
    buf_w_n    = buf_w;
    buf_pc_n   = buf_pc;
    ld         = 1'b0;
    ld_w       = buf_w[31:0];
    ld_pc      = buf_pc;
    case (state)
      IDLE: begin
        state_n = branch_taken_i ? IDLE : REQ;
        pc_n    = branch_taken_i ? tgt : pc;
      end
      REQ: begin
        // a redirect seen mid-cycle is remembered so the bus cycle can finish cleanly
        if (wb_ack_i) begin
          state_n = IDLE;
          pend_n  = 1'b0;
          if (branch_taken_i) pc_n = tgt;
          else if (pend) pc_n = pend_tgt;
          else begin
            pc_n = pc + ADDR_WIDTH'(4);
            if (stall_i) begin
              state_n  = HOLD;
              buf_w_n  = wb_dat_i;
              buf_pc_n = pc;
            end else begin
              ld    = 1'b1;
              ld_w  = wb_dat_i[31:0];
              ld_pc = pc;
            end
          end
        end else if (branch_taken_i) begin
          pend_n     = 1'b1;
          pend_tgt_n = tgt;
        end
      end
      HOLD: begin
        if (branch_taken_i) begin
          pc_n    = tgt;
          state_n = IDLE;
        end else if (!stall_i) begin
          ld      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= PC_ADDR;
      pend          <= 1'b0;
      pend_tgt      <= '0;
      buf_w         <= '0;
      buf_pc        <= '0;
      if_id_valid_o <= 1'b0;
      if_id_pc_o    <= '0;
      instruction   <= NOP;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend     <= pend_n;
      pend_tgt <= pend_tgt_n;
      buf_w    <= buf_w_n;
      buf_pc   <= buf_pc_n;
      if (flush_i) begin
        if_id_valid_o <= 1'b0;
        instruction   <= NOP;
      end else if (!stall_i) begin
        if_id_valid_o <= ld;
        instruction   <= ld ? ld_w : NOP;
        if_id_pc_o    <= ld ? ld_pc : if_id_pc_o;
      end
    end
  end
  assign wb_cyc_o = state == REQ;
  assign wb_stb_o = state == REQ;
  assign wb_adr_o = pc;
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = '1;
  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign I_imm  = instruction[31:20];
  assign S_imm  = {instruction[31:25], instruction[11:7]};
  assign SB_imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
  assign U_imm  = instruction[31:12];
  assign UJ_imm = {instruction[31], instruction[19:12], instruction[20], instruction[30:21]};
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a transaction-level fetch model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, reset = 0, stall_i = 0, flush_i = 0, branch_taken_i = 0, wb_ack_i = 0;
  logic [31:0] branch_target_i = 0, wb_dat_i = 0;
  logic wb_cyc_o, wb_stb_o, wb_we_o, if_id_valid_o;
  logic [31:0] wb_adr_o, wb_dat_o, if_id_pc_o, instruction;
  logic [3:0] wb_sel_o;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [11:0] I_imm, S_imm, SB_imm;
  logic [19:0] U_imm, UJ_imm;
  int vecs = 0, errs = 0, lat = 0, wcnt = 0;
  bit slave_en = 0, model_en = 0, prev_cyc = 0, discard = 0;
  logic [31:0] exp_pc = 32'h8000_0000, req_pc = 0;
  logic [63:0] q[$];

  if_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_adr_o(wb_adr_o),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o), .instruction(instruction),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .I_imm(I_imm), .S_imm(S_imm), .SB_imm(SB_imm), .U_imm(U_imm), .UJ_imm(UJ_imm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0050_0093;
    if (a == 32'h8000_0004) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // immediates rebuilt from the full RISC-V B/J immediates, dropping the implicit zero lsb
  function automatic logic [100:0] fields(input logic [31:0] w);
    logic [12:0] b;
    logic [20:0] j;
    b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    return {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:20], w[31:25], w[11:7],
            b[12:1], w[31:12], j[20:1]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // fetch stream model: expected next fetch address plus FIFO of words owed to ID
  task automatic model();
    logic [63:0] e;
    if (wb_cyc_o && !prev_cyc) begin
      chk("req_adr", wb_adr_o, exp_pc);
      req_pc = exp_pc;
    end else if (wb_cyc_o) chk("adr_stable", wb_adr_o, req_pc);
    if (!if_id_valid_o) chk("bubble_nop", instruction, NOP);
    else if (!stall_i && !branch_taken_i) begin
      if (q.size() == 0) chk("spurious_valid", if_id_valid_o, 0);
      else begin
        e = q.pop_front();
        chk("rand_pc", if_id_pc_o, e[63:32]);
        chk("rand_inst", instruction, e[31:0]);
        chk("rand_fields", {opcode, rd, funct3, rs1, rs2, I_imm, S_imm, SB_imm, U_imm, UJ_imm},
            fields(e[31:0]));
      end
    end
    if (branch_taken_i) begin
      q.delete();
      exp_pc = branch_target_i & ~32'h3;
      if (wb_cyc_o) discard = 1;
    end
    if (wb_cyc_o && wb_ack_i) begin
      if (discard) discard = 0;
      else begin
        q.push_back({req_pc, wb_dat_i});
        exp_pc = req_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    if (slave_en) begin
      wb_ack_i = 0;
      wb_dat_i = 0;
      if (wb_cyc_o) begin
        if (!prev_cyc) wcnt = lat;
        if (wcnt == 0) begin
          wb_ack_i = 1;
          wb_dat_i = mem_word(wb_adr_o);
        end else wcnt--;
      end
    end
    #1;
    if (model_en) model();
    prev_cyc = wb_cyc_o;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    {stall_i, flush_i, branch_taken_i, wb_ack_i} = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    prev_cyc = 0;
    discard = 0;
    q.delete();
    exp_pc = 32'h8000_0000;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_valid", if_id_valid_o, 0);
    chk("rst_inst", instruction, NOP);
    chk("rst_idpc", if_id_pc_o, 0);
    chk("rst_adr", wb_adr_o, 32'h8000_0000);
    chk("const_bus", {wb_we_o, wb_sel_o, wb_dat_o}, {1'b0, 4'hF, 32'h0});
    reset = 1;
    slave_en = 1;
    lat = 0;
    chk("t1_idle", wb_cyc_o, 0);
    tick();
    chk("t1_req0", {wb_cyc_o, wb_stb_o, wb_adr_o}, {2'b11, 32'h8000_0000});
    tick();
    chk("t1_v0", {if_id_valid_o, if_id_pc_o, instruction}, {1'b1, 32'h8000_0000, 32'h0050_0093});
    chk("t1_dec", {opcode, rd, I_imm}, {7'h13, 5'd1, 12'd5});
    chk("t1_idle2", wb_cyc_o, 0);
    tick();
    chk("t1_req1", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h8000_0004});
    tick();
    chk("t1_v1", {if_id_valid_o, if_id_pc_o, instruction}, {1'b1, 32'h8000_0004, 32'h0010_0113});
    do_reset();
    lat = 3;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_wait", {wb_cyc_o, wb_stb_o, wb_adr_o, if_id_valid_o}, {2'b11, 32'h8000_0000, 1'b0});
      tick();
    end
    chk("t2_load", {if_id_valid_o, if_id_pc_o, instruction, wb_cyc_o},
        {1'b1, 32'h8000_0000, 32'h0050_0093, 1'b0});
    lat = 0;
    stall_i = 1;
    tick();
    chk("t3_req", {wb_cyc_o, wb_adr_o, if_id_valid_o, if_id_pc_o},
        {1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", {wb_cyc_o, if_id_valid_o, if_id_pc_o, instruction},
          {1'b0, 1'b1, 32'h8000_0000, 32'h0050_0093});
    end
    stall_i = 0;
    tick();
    chk("t3_release", {if_id_valid_o, if_id_pc_o, instruction, wb_cyc_o},
        {1'b1, 32'h8000_0004, 32'h0010_0113, 1'b0});
    tick();
    chk("t3_next", {wb_cyc_o, wb_adr_o, if_id_valid_o}, {1'b1, 32'h8000_0008, 1'b0});
    lat = 2;
    branch_taken_i = 1;
    flush_i = 1;
    branch_target_i = 32'h8000_0102;
    tick();
    branch_taken_i = 0;
    flush_i = 0;
    chk("t4_noabort", {wb_cyc_o, wb_adr_o, if_id_valid_o}, {1'b1, 32'h8000_0008, 1'b0});
    tick();
    chk("t4_wait", {wb_cyc_o, if_id_valid_o}, {1'b1, 1'b0});
    tick();
    chk("t4_discard", {wb_cyc_o, if_id_valid_o}, {1'b0, 1'b0});
    tick();
    chk("t4_target", {wb_cyc_o, wb_adr_o, if_id_valid_o}, {1'b1, 32'h8000_0100, 1'b0});
    lat = 0;
    tick();
    chk("t5_load", {if_id_valid_o, if_id_pc_o}, {1'b1, 32'h8000_0100});
    stall_i = 1;
    flush_i = 1;
    tick();
    stall_i = 0;
    flush_i = 0;
    chk("t5_flush", {if_id_valid_o, instruction}, {1'b0, NOP});
    chk("t6_busy", wb_cyc_o, 1);
    slave_en = 0;
    wb_ack_i = 0;
    #2 reset = 0;
    #1 chk("t6_async", {wb_cyc_o, wb_stb_o, wb_adr_o, if_id_valid_o}, {2'b00, 32'h8000_0000, 1'b0});
    @(negedge clk);
    reset = 1;
    wb_ack_i = 1;
    wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 0;
    chk("t6_stray", {if_id_valid_o, wb_cyc_o, wb_adr_o}, {1'b0, 1'b1, 32'h8000_0000});
    slave_en = 1;
    tick();
    chk("t6_refetch", {if_id_valid_o, if_id_pc_o, instruction}, {1'b1, 32'h8000_0000, 32'h0050_0093});
    branch_taken_i = 1;
    flush_i = 1;
    branch_target_i = 32'hFFFF_FFFD;
    tick();
    branch_taken_i = 0;
    flush_i = 0;
    chk("wrap_idle", {wb_cyc_o, if_id_valid_o}, {1'b0, 1'b0});
    tick();
    chk("wrap_req", {wb_cyc_o, wb_adr_o}, {1'b1, 32'hFFFF_FFFC});
    tick();
    chk("wrap_load", {if_id_valid_o, if_id_pc_o}, {1'b1, 32'hFFFF_FFFC});
    tick();
    chk("wrap_zero", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h0});
    do_reset();
    model_en = 1;
    for (int i = 0; i < 4000; i++) begin
      stall_i = $urandom_range(0, 3) == 0;
      branch_taken_i = $urandom_range(0, 19) == 0;
      flush_i = branch_taken_i;
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      lat = $urandom_range(0, 3);
      tick();
    end
    model_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
